// File: rtl/bp_cfg_loader.sv
// Boot-time core configuration sequencer: freezes each core, writes its
// per-core configuration registers, then unfreezes every core in order.
// All writes go out on one valid/ready config-write channel.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start_i after reset
// CONFIG   | writing register w (0..4) of core c
// UNFREEZE | writing freeze=0 to core c
// DONE     | pass complete, done_o held until next start_i or reset_i
module bp_cfg_loader #(
  parameter int num_core_p       = 4,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter int core_id_width_p  = 6
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  logic                        cce_mode_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [core_id_width_p-1:0]  cfg_core_id_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  output logic                        busy_o,
  output logic                        done_o
);

  typedef enum logic [1:0] {IDLE, CONFIG, UNFREEZE, DONE} state_e;

  localparam logic [core_id_width_p-1:0]  last_core_lp  = core_id_width_p'(num_core_p - 1);
  localparam logic [2:0]                  last_w_lp     = 3'd4;
  localparam logic [cfg_addr_width_p-1:0] addr_freeze_lp = cfg_addr_width_p'(1);
  localparam logic [cfg_addr_width_p-1:0] addr_hart_lp   = cfg_addr_width_p'(2);
  localparam logic [cfg_addr_width_p-1:0] addr_icache_lp = cfg_addr_width_p'(3);
  localparam logic [cfg_addr_width_p-1:0] addr_dcache_lp = cfg_addr_width_p'(4);
  localparam logic [cfg_addr_width_p-1:0] addr_cce_lp    = cfg_addr_width_p'(5);

  state_e                      state_q, state_d;
  logic [2:0]                  w_q, w_d;
  logic [core_id_width_p-1:0]  c_q, c_d;
  logic                        mode_q, mode_d;
  logic                        done_q, done_d;
  logic                        cfg_v_q, cfg_v_d;
  logic [core_id_width_p-1:0]  core_id_q, core_id_d;
  logic [cfg_addr_width_p-1:0] addr_q, addr_d;
  logic [cfg_data_width_p-1:0] data_q, data_d;
  logic                        accept;

  assign accept = cfg_v_q & cfg_ready_i;

  // Next-state logic: walk w within a core, then c across cores, then unfreeze.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    c_d     = c_q;
    mode_d  = mode_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = CONFIG;
          w_d     = 3'd0;
          c_d     = '0;
          mode_d  = cce_mode_i;
          done_d  = 1'b0;
        end
      end
      CONFIG: begin
        if (accept) begin
          if (w_q == last_w_lp) begin
            w_d = 3'd0;
            if (c_q == last_core_lp) begin
              state_d = UNFREEZE;
              c_d     = '0;
            end else begin
              c_d = c_q + 1'b1;
            end
          end else begin
            w_d = w_q + 3'd1;
          end
        end
      end
      UNFREEZE: begin
        if (accept) begin
          if (c_q == last_core_lp) begin
            state_d = DONE;
            c_d     = '0;
            done_d  = 1'b1;
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload for the next cycle, decoded from the next state so outputs come straight from flops.
  always_comb begin
    cfg_v_d   = 1'b0;
    core_id_d = '0;
    addr_d    = '0;
    data_d    = '0;
    if (state_d == CONFIG) begin
      cfg_v_d   = 1'b1;
      core_id_d = c_d;
      unique case (w_d)
        3'd0:    begin addr_d = addr_freeze_lp; data_d = cfg_data_width_p'(1);      end
        3'd1:    begin addr_d = addr_hart_lp;   data_d = cfg_data_width_p'(c_d);    end
        3'd2:    begin addr_d = addr_icache_lp; data_d = cfg_data_width_p'(1);      end
        3'd3:    begin addr_d = addr_dcache_lp; data_d = cfg_data_width_p'(1);      end
        default: begin addr_d = addr_cce_lp;    data_d = cfg_data_width_p'(mode_d); end
      endcase
    end else if (state_d == UNFREEZE) begin
      cfg_v_d   = 1'b1;
      core_id_d = c_d;
      addr_d    = addr_freeze_lp;
      data_d    = '0;
    end
  end

  // State, counters and registered payload with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      w_q       <= 3'd0;
      c_q       <= '0;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_v_q   <= 1'b0;
      core_id_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      c_q       <= c_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      cfg_v_q   <= cfg_v_d;
      core_id_q <= core_id_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign cfg_v_o       = cfg_v_q;
  assign cfg_core_id_o = core_id_q;
  assign cfg_addr_o    = addr_q;
  assign cfg_data_o    = data_q;
  assign busy_o        = (state_q == CONFIG) || (state_q == UNFREEZE);
  assign done_o        = done_q;

  // A stalled write must hold its payload and valid until accepted.
  a_payload_stable: assert property (@(posedge clk_i) disable iff (reset_i)
    (cfg_v_o && !cfg_ready_i) |=> (cfg_v_o && $stable({cfg_core_id_o, cfg_addr_o, cfg_data_o})));

  // Nothing is offered on the channel outside an active pass.
  a_no_valid_idle: assert property (@(posedge clk_i)
    ((state_q == IDLE) || (state_q == DONE)) |-> !cfg_v_o);

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Directed bench for bp_cfg_loader: a 4-core and a 1-core instance share inputs.
module tb_bp_cfg_loader;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic reset_i, start_i, cce_mode_i, cfg_ready_i;

  logic        v4, busy4, done4;
  logic [5:0]  core4;
  logic [15:0] addr4;
  logic [63:0] data4;
  logic        v1, busy1, done1;
  logic [5:0]  core1;
  logic [15:0] addr1;
  logic [63:0] data1;

  bp_cfg_loader #(.num_core_p(4), .cfg_addr_width_p(16), .cfg_data_width_p(64), .core_id_width_p(6)) dut4 (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .cce_mode_i(cce_mode_i),
    .cfg_v_o(v4), .cfg_ready_i(cfg_ready_i), .cfg_core_id_o(core4), .cfg_addr_o(addr4),
    .cfg_data_o(data4), .busy_o(busy4), .done_o(done4));

  bp_cfg_loader #(.num_core_p(1), .cfg_addr_width_p(16), .cfg_data_width_p(64), .core_id_width_p(6)) dut1 (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .cce_mode_i(cce_mode_i),
    .cfg_v_o(v1), .cfg_ready_i(cfg_ready_i), .cfg_core_id_o(core1), .cfg_addr_o(addr1),
    .cfg_data_o(data1), .busy_o(busy1), .done_o(done1));

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  // Accepted writes as {addr[15:0], data[63:0], core[5:0]}.
  logic [85:0] acc_word[$];
  int          acc_cyc[$];
  int          done_cyc;
  int          stall_err;
  logic        done_first;

  // Reference write k of a pass over n cores.
  function automatic logic [85:0] exp_word(input int k, input int n, input logic mode);
    logic [15:0] a;
    logic [63:0] d;
    logic [5:0]  id;
    int c, w;
    if (k < 5 * n) begin
      c = k / 5;
      w = k % 5;
      a = 16'(w + 1);
      id = 6'(c);
      case (w)
        1:       d = 64'(c);
        4:       d = {63'd0, mode};
        default: d = 64'd1;
      endcase
    end else begin
      a = 16'h0001;
      d = 64'd0;
      id = 6'(k - 5 * n);
    end
    return {a, d, id};
  endfunction

  // Runs cycles after a start pulse in period sp, logging accepts until done_o rises.
  task automatic collect(input int sel, input int sp, input int bp, input int repulse_off, input int max_cyc);
    logic        sv, sd, hold_v;
    logic [85:0] sw, hw;
    acc_word.delete();
    acc_cyc.delete();
    done_cyc = -1;
    stall_err = 0;
    hold_v = 1'b0;
    hw = '0;
    done_first = 1'bx;
    for (int i = 0; i < max_cyc && done_cyc < 0; i++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (repulse_off > 0 && cyc == sp + repulse_off) begin
        start_i = 1'b1;
        cce_mode_i = 1'b0;
      end
      cfg_ready_i = (bp == 0) ? 1'b1 : (((cyc - sp) % 2) == 0);
      @(negedge clk_i);
      if (sel == 1) begin sv = v1; sd = done1; sw = {addr1, data1, core1}; end
      else          begin sv = v4; sd = done4; sw = {addr4, data4, core4}; end
      if (i == 0) done_first = sd;
      if (hold_v && (!sv || sw !== hw)) stall_err++;
      if (sv && cfg_ready_i) begin
        acc_word.push_back(sw);
        acc_cyc.push_back(cyc);
      end
      hold_v = sv && !cfg_ready_i;
      hw = sw;
      if (sd) done_cyc = cyc;
    end
    start_i = 1'b0;
    cfg_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; start_i = 1'b0; cce_mode_i = 1'b0; cfg_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    tests_run++; if (v4 !== 1'b0) begin tests_failed++; $display("FAIL reset_v: got %b expected 0", v4); end
    tests_run++; if (busy4 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy4); end
    tests_run++; if (done4 !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done4); end
    tests_run++; if ({addr4, data4, core4} !== 86'd0) begin tests_failed++; $display("FAIL reset_payload: got %0h expected 0", {addr4, data4, core4}); end
    tests_run++; if ({v1, busy1, done1} !== 3'b000) begin tests_failed++; $display("FAIL reset_dut1: got %b expected 000", {v1, busy1, done1}); end
  endtask

  task automatic test_continuous();
    int sp;
    cce_mode_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b1; sp = cyc;
    collect(4, sp, 0, 0, 100);
    tests_run++; if (acc_word.size() != 24) begin tests_failed++; $display("FAIL cont_count: got %0d expected 24", acc_word.size()); end
    for (int k = 0; k < acc_word.size() && k < 24; k++) begin
      tests_run++;
      if (acc_word[k] !== exp_word(k, 4, 1'b1)) begin tests_failed++; $display("FAIL cont_write%0d: got %0h expected %0h", k, acc_word[k], exp_word(k, 4, 1'b1)); end
    end
    tests_run++; if ((acc_cyc.size() > 0 ? acc_cyc[0] : -1) != sp + 1) begin tests_failed++; $display("FAIL cont_first_cyc: got %0d expected %0d", acc_cyc.size() > 0 ? acc_cyc[0] : -1, sp + 1); end
    tests_run++; if ((acc_cyc.size() > 0 ? acc_cyc[acc_cyc.size()-1] : -1) != sp + 24) begin tests_failed++; $display("FAIL cont_last_cyc: got %0d expected %0d", acc_cyc.size() > 0 ? acc_cyc[acc_cyc.size()-1] : -1, sp + 24); end
    tests_run++; if (done_cyc != sp + 25) begin tests_failed++; $display("FAIL cont_done_cyc: got %0d expected %0d", done_cyc, sp + 25); end
    tests_run++; if ({v4, busy4} !== 2'b00) begin tests_failed++; $display("FAIL cont_done_idle: got %b expected 00", {v4, busy4}); end
  endtask

  task automatic test_backpressure();
    int sp;
    cce_mode_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b1; sp = cyc;
    collect(4, sp, 1, 0, 200);
    tests_run++; if (acc_word.size() != 24) begin tests_failed++; $display("FAIL bp_count: got %0d expected 24", acc_word.size()); end
    for (int k = 0; k < acc_word.size() && k < 24; k++) begin
      tests_run++;
      if (acc_word[k] !== exp_word(k, 4, 1'b1)) begin tests_failed++; $display("FAIL bp_write%0d: got %0h expected %0h", k, acc_word[k], exp_word(k, 4, 1'b1)); end
    end
    tests_run++; if (stall_err != 0) begin tests_failed++; $display("FAIL bp_hold: got %0d unstable stalls expected 0", stall_err); end
    tests_run++; if (done_cyc != sp + 49) begin tests_failed++; $display("FAIL bp_done_cyc: got %0d expected %0d", done_cyc, sp + 49); end
  endtask

  task automatic test_restart_ignored();
    int sp, n_cce;
    cce_mode_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b1; sp = cyc;
    collect(4, sp, 0, 7, 100);
    tests_run++; if (acc_word.size() != 24) begin tests_failed++; $display("FAIL restart_count: got %0d expected 24", acc_word.size()); end
    n_cce = 0;
    for (int k = 0; k < acc_word.size() && k < 24; k++) begin
      if (acc_word[k][85:70] == 16'h0005 && acc_word[k][69:6] == 64'd1) n_cce++;
      tests_run++;
      if (acc_word[k] !== exp_word(k, 4, 1'b1)) begin tests_failed++; $display("FAIL restart_write%0d: got %0h expected %0h", k, acc_word[k], exp_word(k, 4, 1'b1)); end
    end
    tests_run++; if (n_cce != 4) begin tests_failed++; $display("FAIL restart_cce_mode: got %0d writes of 1 expected 4", n_cce); end
    tests_run++; if (done_cyc != sp + 25) begin tests_failed++; $display("FAIL restart_done_cyc: got %0d expected %0d", done_cyc, sp + 25); end
  endtask

  task automatic test_single_core();
    int sp;
    logic [85:0] exp1 [6];
    exp1[0] = {16'h1, 64'd1, 6'd0};
    exp1[1] = {16'h2, 64'd0, 6'd0};
    exp1[2] = {16'h3, 64'd1, 6'd0};
    exp1[3] = {16'h4, 64'd1, 6'd0};
    exp1[4] = {16'h5, 64'd1, 6'd0};
    exp1[5] = {16'h1, 64'd0, 6'd0};
    cce_mode_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b1; sp = cyc;
    collect(1, sp, 0, 0, 50);
    tests_run++; if (acc_word.size() != 6) begin tests_failed++; $display("FAIL single_count: got %0d expected 6", acc_word.size()); end
    for (int k = 0; k < acc_word.size() && k < 6; k++) begin
      tests_run++;
      if (acc_word[k] !== exp1[k]) begin tests_failed++; $display("FAIL single_write%0d: got %0h expected %0h", k, acc_word[k], exp1[k]); end
    end
    tests_run++; if (done_cyc != sp + 7) begin tests_failed++; $display("FAIL single_done_cyc: got %0d expected %0d", done_cyc, sp + 7); end
    repeat (30) @(posedge clk_i);
  endtask

  task automatic test_reset_mid_pass();
    int sp;
    cce_mode_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b1; sp = cyc;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_i); #1 start_i = 1'b0; cfg_ready_i = 1'b1;
    end
    @(posedge clk_i); #1 cfg_ready_i = 1'b0; reset_i = 1'b1;
    @(negedge clk_i);
    tests_run++; if ({v4, addr4, core4} !== {1'b1, 16'h3, 6'd2}) begin tests_failed++; $display("FAIL rst_pending: got %0h expected %0h", {v4, addr4, core4}, {1'b1, 16'h3, 6'd2}); end
    @(posedge clk_i); #1 reset_i = 1'b0; cfg_ready_i = 1'b1;
    @(negedge clk_i);
    tests_run++; if ({v4, done4, busy4} !== 3'b000) begin tests_failed++; $display("FAIL rst_after: got %b expected 000", {v4, done4, busy4}); end
    @(posedge clk_i); #1 start_i = 1'b1; sp = cyc;
    collect(4, sp, 0, 0, 100);
    tests_run++; if (acc_word.size() != 24) begin tests_failed++; $display("FAIL rst_count: got %0d expected 24", acc_word.size()); end
    tests_run++; if ((acc_word.size() > 0 ? acc_word[0] : 86'd0) !== {16'h1, 64'd1, 6'd0}) begin tests_failed++; $display("FAIL rst_first: got %0h expected %0h", acc_word.size() > 0 ? acc_word[0] : 86'd0, {16'h1, 64'd1, 6'd0}); end
    tests_run++; if (done_cyc != sp + 25) begin tests_failed++; $display("FAIL rst_done_cyc: got %0d expected %0d", done_cyc, sp + 25); end
  endtask

  task automatic test_back_to_back();
    int sp;
    @(negedge clk_i);
    tests_run++; if (done4 !== 1'b1) begin tests_failed++; $display("FAIL b2b_pre_done: got %b expected 1", done4); end
    @(posedge clk_i); #1 start_i = 1'b1; cce_mode_i = 1'b0; sp = cyc;
    collect(4, sp, 0, 0, 100);
    tests_run++; if (done_first !== 1'b0) begin tests_failed++; $display("FAIL b2b_done_clear: got %b expected 0", done_first); end
    tests_run++; if (acc_word.size() != 24) begin tests_failed++; $display("FAIL b2b_count: got %0d expected 24", acc_word.size()); end
    for (int k = 0; k < acc_word.size() && k < 24; k++) begin
      tests_run++;
      if (acc_word[k] !== exp_word(k, 4, 1'b0)) begin tests_failed++; $display("FAIL b2b_write%0d: got %0h expected %0h", k, acc_word[k], exp_word(k, 4, 1'b0)); end
    end
    tests_run++; if (done_cyc != sp + 25) begin tests_failed++; $display("FAIL b2b_done_cyc: got %0d expected %0d", done_cyc, sp + 25); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_backpressure();
    test_restart_ignored();
    test_single_core();
    test_reset_mid_pass();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
